// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator feeding fetch: boot hold, +4 advance, stall, redirect, trap, debug halt.
// Optional PC_MISALIGN_CHECK_EN: drop misaligned redirects and report them on misalign_o/misalign_addr_o.
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             trap_valid_i,
  input  logic [31:0]      trap_vec_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             pc_valid_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] fetch_count_o
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic             misalign_o,
  output logic [31:0]      misalign_addr_o
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // BOOT_CYCLES of 0 and 1 both leave BOOT on the first edge.
  localparam logic [3:0] BOOT_LAST = 4'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [3:0]       boot_cnt, boot_nxt;
  logic [31:0]      pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      trap_target;
  logic [31:0]      redir_target;
  logic             redir_take;

  assign trap_target  = {trap_vec_i[31:2], 2'b00};
  assign redir_target = {redirect_pc_i[31:2], 2'b00};

`ifdef PC_MISALIGN_CHECK_EN
  logic        redir_bad;
  logic        mis_nxt;
  logic [31:0] mis_addr_nxt;
  logic        unused_bits;

  assign redir_bad   = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign redir_take  = redirect_valid_i && !redir_bad;
  assign unused_bits = ^trap_vec_i[1:0];
`else
  logic unused_bits;

  assign redir_take  = redirect_valid_i;
  assign unused_bits = ^{trap_vec_i[1:0], redirect_pc_i[1:0]};
`endif

  always_comb begin
    state_nxt = state;
    boot_nxt  = boot_cnt;
    pc_nxt    = pc_o;
    cnt_nxt   = fetch_count_o;
    case (state)
      ST_BOOT: begin
        if (boot_cnt >= BOOT_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          boot_nxt = boot_cnt + 4'd1;
        end
      end
      ST_RUN: begin
        if (!stall_i) begin
          cnt_nxt = fetch_count_o + CNT_W'(1);
        end
        if (trap_valid_i) begin
          pc_nxt = trap_target;
        end else begin
          if (redir_take) begin
            pc_nxt = redir_target;
          end else if (!stall_i) begin
            pc_nxt = pc_o + 32'd4;
          end
          if (halt_i) begin
            state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // Stall is meaningless while halted; only trap, redirect and resume act.
        if (trap_valid_i) begin
          pc_nxt    = trap_target;
          state_nxt = ST_RUN;
        end else begin
          if (redir_take) begin
            pc_nxt = redir_target;
          end
          if (resume_i && !halt_i) begin
            state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        state_nxt = ST_BOOT;
        boot_nxt  = 4'd0;
        pc_nxt    = RESET_VECTOR;
      end
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_comb begin
    mis_nxt      = 1'b0;
    mis_addr_nxt = misalign_addr_o;
    if ((state == ST_RUN || state == ST_HALT) && !trap_valid_i && redir_bad) begin
      mis_nxt      = 1'b1;
      mis_addr_nxt = redirect_pc_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= 32'h0000_0000;
    end else begin
      misalign_o      <= mis_nxt;
      misalign_addr_o <= mis_addr_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_BOOT;
      boot_cnt      <= 4'd0;
      pc_o          <= RESET_VECTOR;
      fetch_count_o <= '0;
    end else begin
      state         <= state_nxt;
      boot_cnt      <= boot_nxt;
      pc_o          <= pc_nxt;
      fetch_count_o <= cnt_nxt;
    end
  end

  assign pc_plus4_o = pc_o + 32'd4;
  assign pc_valid_o = (state == ST_RUN);
  assign state_o    = state;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen: directed scenarios plus random stimulus against a reference model.
module tb_pc_gen;

  localparam int BOOT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_vec_i = 32'h0;
  logic        halt_i = 1'b0;
  logic        resume_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;
  logic [1:0]  state_o;
  logic [31:0] fetch_count_o;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  always #5 clk = ~clk;

  pc_gen #(
    .RESET_VECTOR(32'h0000_0000),
    .BOOT_CYCLES (BOOT_CYCLES),
    .CNT_W       (32)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall_i         (stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .trap_valid_i    (trap_valid_i),
    .trap_vec_i      (trap_vec_i),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .pc_valid_o      (pc_valid_o),
    .state_o         (state_o),
    .fetch_count_o   (fetch_count_o)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        mis;
    logic [31:0] maddr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: mode 0 = BOOT, 1 = RUN, 2 = HALT.
  int          m_mode;
  int          m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;
  logic [31:0] m_maddr;

  task automatic model_step();
    logic        take;
    logic        misaligned;
    logic [31:0] tgt;
    misaligned = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    misaligned = redirect_valid_i && (redirect_pc_i % 4 != 0);
`endif
    take = redirect_valid_i && !misaligned;
    tgt  = redirect_pc_i - (redirect_pc_i % 4);
    if (!reset_n) begin
      m_mode = 0; m_boot = 0; m_pc = 32'h0; m_cnt = 32'h0; m_mis = 1'b0; m_maddr = 32'h0;
    end else begin
      m_mis = 1'b0;
      if (m_mode != 0 && !trap_valid_i && misaligned) begin
        m_mis   = 1'b1;
        m_maddr = redirect_pc_i;
      end
      if (m_mode == 0) begin
        m_boot = m_boot + 1;
        if (m_boot >= ((BOOT_CYCLES == 0) ? 1 : BOOT_CYCLES)) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!stall_i) m_cnt = m_cnt + 1;
        if (trap_valid_i) m_pc = trap_vec_i - (trap_vec_i % 4);
        else begin
          if (take) m_pc = tgt;
          else if (!stall_i) m_pc = m_pc + 4;
          if (halt_i) m_mode = 2;
        end
      end else begin
        if (trap_valid_i) begin
          m_pc   = trap_vec_i - (trap_vec_i % 4);
          m_mode = 1;
        end else begin
          if (take) m_pc = tgt;
          if (resume_i && !halt_i) m_mode = 1;
        end
      end
    end
  endtask

  task automatic drive(input logic rn, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic tv, input logic [31:0] tvec, input logic h, input logic r);
    exp_t e;
    @(negedge clk);
    reset_n = rn; stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc;
    trap_valid_i = tv; trap_vec_i = tvec; halt_i = h; resume_i = r;
    model_step();
    e.pc = m_pc; e.valid = (m_mode == 1); e.st = 2'(m_mode); e.cnt = m_cnt;
    e.mis = m_mis; e.maddr = m_maddr;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("pc_plus4_o", pc_plus4_o, e.pc + 32'd4);
        chk("pc_valid_o", {31'b0, pc_valid_o}, {31'b0, e.valid});
        chk("state_o", {30'b0, state_o}, {30'b0, e.st});
        chk("fetch_count_o", fetch_count_o, e.cnt);
`ifdef PC_MISALIGN_CHECK_EN
        chk("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
        chk("misalign_addr_o", misalign_addr_o, e.maddr);
`endif
      end
    end
  end

  initial begin : stimulus
    logic        h_lvl;
    logic [31:0] rpc;
    h_lvl = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h88, 1'b0, 1'b0);
    // boot window ignores all inputs, then 0,4,8,...
    drive(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 1'b1);
    idle(3);
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h8000_0003, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(2);
    // halt at 0x10, held halt, resume ignored while halt_i high, then resume
    drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    // trap beats halt; then halt with redirect, trap exits halt
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0800, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h60, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h70, 1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0902, 1'b1, 1'b0);
    // misaligned redirect 0x202 at pc 0x20, and one masked by a trap
    drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h202, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 1'b0, 1'b1, 32'h333, 1'b1, 32'h1000, 1'b0, 1'b0);
    idle(1);
    // reset mid-operation
    drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) h_lvl = ~h_lvl;
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      drive(($urandom_range(299) != 0),
            ($urandom_range(3) == 0),
            ($urandom_range(6) == 0), rpc,
            ($urandom_range(19) == 0), $urandom,
            h_lvl,
            ($urandom_range(4) == 0));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
